// File: rtl/divider_pkg.sv
// Shared types and helpers for the divider array: controller state encoding,
// lane-to-divisor mapping and the iteration-counter width.
package divider_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Lane i is served by divisor i / group.
  function automatic int unsigned div_index(input int unsigned lane, input int unsigned group);
    return lane / group;
  endfunction

  // Counter must hold width-1 on load.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/divider_lane.sv
// One restoring-divider lane. The dividend register doubles as the quotient
// register: dividend bits leave at the top while quotient bits enter at the bottom.
module divider_lane #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             last,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic             zero_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             div_zero_q;

  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;

  always_comb begin
    shifted = {rem_q, dvd_q[WIDTH-1]};
    fits    = shifted >= {1'b0, dvs_q};
    // When fits is set the difference is below the divisor, so WIDTH bits suffice.
    rem_d   = fits ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
    dvd_d   = {dvd_q[WIDTH-2:0], fits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else if (load) begin
      dvd_q  <= dividend;
      dvs_q  <= divisor;
      rem_q  <= '0;
      zero_q <= (divisor == '0);
    end else if (step) begin
      dvd_q <= dvd_d;
      rem_q <= rem_d;
      if (last) begin
        quotient_q  <= zero_q ? '1 : dvd_d;
        remainder_q <= rem_d;
        div_zero_q  <= zero_q;
      end
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: rtl/divider_array.sv
// Multi-channel handshaked unsigned divider: one shared controller steps
// CHANNELS lock-stepped lanes, with each divisor shared by GROUP lanes.
module divider_array
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH    = 9,
  parameter int unsigned CHANNELS = 6,
  parameter int unsigned GROUP    = 2,
  localparam int unsigned NDIV    = CHANNELS / GROUP
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               in_valid_in,
  output logic                               in_ready_out,
  input  logic [CHANNELS-1:0][WIDTH-1:0]     dividend_in,
  input  logic [NDIV-1:0][WIDTH-1:0]         divisor_in,
  output logic                               out_valid_out,
  input  logic                               out_ready_in,
  output logic [CHANNELS-1:0][WIDTH-1:0]     quotient_out,
  output logic [CHANNELS-1:0][WIDTH-1:0]     remainder_out,
  output logic [CHANNELS-1:0]                div_zero_out,
  output logic                               busy_out
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH - 1);

  if ((CHANNELS % GROUP) != 0) begin : g_bad_group
    $error("divider_array: CHANNELS must be a multiple of GROUP");
  end

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            out_valid_q;
  logic            busy_q;

  logic accept;
  logic step;
  logic last;

  always_comb begin
    in_ready_out = (state_q == StIdle) || ((state_q == StDone) && out_ready_in);
    accept       = in_valid_in && in_ready_out;
    step         = (state_q == StRun);
    last         = step && (cnt_q == '0);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StRun;
            cnt_q   <= CntLoad;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          if (last) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StDone: begin
          if (out_ready_in) begin
            out_valid_q <= 1'b0;
            // Result retires and the next operands load on the same edge.
            if (in_valid_in) begin
              state_q <= StRun;
              cnt_q   <= CntLoad;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid_out = out_valid_q;
  assign busy_out      = busy_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    divider_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk      (clk_in),
      .rst_n    (rst_in),
      .load     (accept),
      .step     (step),
      .last     (last),
      .dividend (dividend_in[i]),
      .divisor  (divisor_in[div_index(i, GROUP)]),
      .quotient (quotient_out[i]),
      .remainder(remainder_out[i]),
      .div_zero (div_zero_out[i])
    );
  end

endmodule

// File: tb/tb_divider_array.sv
// Self-checking bench for divider_array: directed cases, backpressure,
// back-to-back, reset mid-run, 16-bit extremes and randomised traffic.
module tb_divider_array;

  localparam int W   = 9;
  localparam int C   = 6;
  localparam int G   = 2;
  localparam int ND  = C / G;
  localparam int W2  = 16;
  localparam int C2  = 4;
  localparam int G2  = 4;
  localparam int ND2 = C2 / G2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
  logic [C-1:0][W-1:0]  dvd = '0, quo, rem;
  logic [ND-1:0][W-1:0] dvs = '0;
  logic [C-1:0]         dz;

  logic                   b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_busy;
  logic [C2-1:0][W2-1:0]  b_dvd = '0, b_quo, b_rem;
  logic [ND2-1:0][W2-1:0] b_dvs = '0;
  logic [C2-1:0]          b_dz;

  divider_array #(.WIDTH(W), .CHANNELS(C), .GROUP(G)) dut (
    .clk_in(clk), .rst_in(rst_n), .in_valid_in(in_valid), .in_ready_out(in_ready),
    .dividend_in(dvd), .divisor_in(dvs), .out_valid_out(out_valid), .out_ready_in(out_ready),
    .quotient_out(quo), .remainder_out(rem), .div_zero_out(dz), .busy_out(busy)
  );

  divider_array #(.WIDTH(W2), .CHANNELS(C2), .GROUP(G2)) dut_b (
    .clk_in(clk), .rst_in(rst_n), .in_valid_in(b_in_valid), .in_ready_out(b_in_ready),
    .dividend_in(b_dvd), .divisor_in(b_dvs), .out_valid_out(b_out_valid),
    .out_ready_in(b_out_ready), .quotient_out(b_quo), .remainder_out(b_rem),
    .div_zero_out(b_dz), .busy_out(b_busy)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int got = 0;
  logic acc = 1'b0;
  logic hold = 1'b0;
  logic [C-1:0][W-1:0] hold_q, hold_r;
  logic [C-1:0]        hold_z;
  logic [C-1:0][W-1:0] q_exp[$];
  logic [C-1:0][W-1:0] r_exp[$];
  logic [C-1:0]        z_exp[$];
  int                  out_cyc[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; zero divisor yields all-ones and the dividend.
  function automatic void model(input logic [C-1:0][W-1:0] a, input logic [ND-1:0][W-1:0] d,
                                output logic [C-1:0][W-1:0] q, output logic [C-1:0][W-1:0] r,
                                output logic [C-1:0] z);
    for (int i = 0; i < C; i++) begin
      int unsigned av, dv;
      av = a[i];
      dv = d[i / G];
      if (dv == 0) begin
        q[i] = W'((1 << W) - 1);
        r[i] = a[i];
        z[i] = 1'b1;
      end else begin
        q[i] = W'(av / dv);
        r[i] = W'(av % dv);
        z[i] = 1'b0;
      end
    end
  endfunction

  // One clock of traffic on the 9-bit instance; scoreboard and hold checks included.
  task automatic step_a(input logic vin, input logic rdy,
                        input logic [C-1:0][W-1:0] a, input logic [ND-1:0][W-1:0] d);
    logic [C-1:0][W-1:0] eq, er;
    logic [C-1:0]        ez;
    @(negedge clk);
    in_valid = vin;
    out_ready = rdy;
    dvd = a;
    dvs = d;
    #1;
    cyc++;
    if (hold) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_q", 64'(quo), 64'(hold_q));
      check("hold_r", 64'(rem), 64'(hold_r));
      check("hold_z", 64'(dz), 64'(hold_z));
    end
    acc = in_valid && in_ready;
    if (acc) begin
      model(a, d, eq, er, ez);
      q_exp.push_back(eq);
      r_exp.push_back(er);
      z_exp.push_back(ez);
    end
    if (out_valid && out_ready) begin
      if (q_exp.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        eq = q_exp.pop_front();
        er = r_exp.pop_front();
        ez = z_exp.pop_front();
        check("res_q", 64'(quo), 64'(eq));
        check("res_r", 64'(rem), 64'(er));
        check("res_z", 64'(dz), 64'(ez));
        got++;
        out_cyc.push_back(cyc);
      end
    end
    hold = out_valid && !out_ready;
    hold_q = quo;
    hold_r = rem;
    hold_z = dz;
  endtask

  task automatic rand_ops(output logic [C-1:0][W-1:0] a, output logic [ND-1:0][W-1:0] d);
    for (int i = 0; i < C; i++) a[i] = W'($urandom);
    for (int j = 0; j < ND; j++) begin
      case ($urandom_range(0, 3))
        0:       d[j] = '0;
        1:       d[j] = W'($urandom_range(1, 8));
        default: d[j] = W'($urandom);
      endcase
    end
  endtask

  task automatic run_b(input logic [C2-1:0][W2-1:0] a, input logic [W2-1:0] d,
                       input int q0, input int r0);
    logic [C2-1:0][W2-1:0] eq, er;
    logic [C2-1:0]         ez;
    int n;
    for (int i = 0; i < C2; i++) begin
      ez[i] = (d == 0);
      eq[i] = (d == 0) ? '1 : a[i] / d;
      er[i] = (d == 0) ? a[i] : a[i] % d;
    end
    @(negedge clk);
    b_in_valid = 1'b1;
    b_dvd = a;
    b_dvs[0] = d;
    b_out_ready = 1'b0;
    #1 check("b_in_ready", 64'(b_in_ready), 64'd1);
    @(negedge clk);
    b_in_valid = 1'b0;
    n = 0;
    while (!b_out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("b_latency", 64'(n), 64'd16);
    check("b_q", 64'(b_quo), 64'(eq));
    check("b_r", 64'(b_rem), 64'(er));
    check("b_z", 64'(b_dz), 64'(ez));
    check("b_q0", 64'(b_quo[0]), 64'(q0));
    check("b_r0", 64'(b_rem[0]), 64'(r0));
    b_out_ready = 1'b1;
    @(negedge clk);
    check("b_consumed", 64'(b_out_valid), 64'd0);
    b_out_ready = 1'b0;
  endtask

  initial begin
    logic [C-1:0][W-1:0]  def_a, ra, zero_a;
    logic [ND-1:0][W-1:0] def_d, rd, zero_d;
    logic [C-1:0][W-1:0]  sa[3];
    logic [ND-1:0][W-1:0] sd[3];
    logic [C2-1:0][W2-1:0] ba;
    int da[6] = '{100, 255, 7, 0, 511, 300};
    int dd[3] = '{7, 1, 0};
    int sq[6] = '{14, 36, 7, 0, 511, 511};
    int sr[6] = '{2, 3, 0, 0, 511, 300};
    int sz[6] = '{0, 0, 0, 0, 1, 1};
    int n, idx, base, early, issued, target;
    logic pend;

    for (int i = 0; i < C; i++) def_a[i] = W'(da[i]);
    for (int j = 0; j < ND; j++) def_d[j] = W'(dd[j]);
    zero_a = '0;
    zero_d = '0;

    // Reset state
    #12;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_q", 64'(quo), 64'd0);
    check("rst_r", 64'(rem), 64'd0);
    check("rst_z", 64'(dz), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Default vectors, latency and no early output update
    step_a(1'b1, 1'b0, def_a, def_d);
    check("def_accept", 64'(acc), 64'd1);
    early = 0;
    for (n = 1; n <= 30; n++) begin
      step_a(1'b0, 1'b0, zero_a, zero_d);
      if (out_valid) break;
      if (quo != '0 || rem != '0) early++;
      if (n == 3) check("run_busy", 64'(busy), 64'd1);
    end
    check("def_latency", 64'(n - 1), 64'd9);
    check("no_early_out", 64'(early), 64'd0);
    for (int i = 0; i < C; i++) begin
      check($sformatf("def_q%0d", i), 64'(quo[i]), 64'(sq[i]));
      check($sformatf("def_r%0d", i), 64'(rem[i]), 64'(sr[i]));
      check($sformatf("def_z%0d", i), 64'(dz[i]), 64'(sz[i]));
    end

    // Backpressure: stall 20 cycles with a competing valid
    rand_ops(ra, rd);
    for (int k = 0; k < 20; k++) begin
      step_a(1'b1, 1'b0, ra, rd);
      check("bp_ready", 64'(in_ready), 64'd0);
    end
    check("bp_ignored", 64'(q_exp.size()), 64'd1);
    base = got;
    step_a(1'b0, 1'b1, zero_a, zero_d);
    for (int k = 0; k < 12; k++) step_a(1'b0, 1'b1, zero_a, zero_d);
    check("bp_once", 64'(got - base), 64'd1);
    check("bp_idle", 64'(busy), 64'd0);

    // Back-to-back with three distinct operand sets
    for (int s = 0; s < 3; s++) rand_ops(sa[s], sd[s]);
    out_cyc.delete();
    base = got;
    idx = 0;
    for (int k = 0; k < 80 && (got - base) < 3; k++) begin
      step_a(idx < 3, 1'b1, sa[idx % 3], sd[idx % 3]);
      if (acc) idx++;
    end
    check("b2b_count", 64'(got - base), 64'd3);
    if (out_cyc.size() == 3) begin
      check("b2b_gap1", 64'(out_cyc[1] - out_cyc[0]), 64'd10);
      check("b2b_gap2", 64'(out_cyc[2] - out_cyc[1]), 64'd10);
    end

    // Reset in the middle of a divide
    rand_ops(ra, rd);
    step_a(1'b1, 1'b1, ra, rd);
    for (int k = 0; k < 4; k++) step_a(1'b0, 1'b1, zero_a, zero_d);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    check("mid_rst_q", 64'(quo), 64'd0);
    check("mid_rst_r", 64'(rem), 64'd0);
    check("mid_rst_z", 64'(dz), 64'd0);
    q_exp.delete();
    r_exp.delete();
    z_exp.delete();
    hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ra = def_a;
    rd = def_d;
    ra[0] = W'(200);
    rd[0] = W'(3);
    step_a(1'b1, 1'b0, ra, rd);
    for (n = 0; n < 30 && !out_valid; n++) step_a(1'b0, 1'b0, zero_a, zero_d);
    check("post_rst_q", 64'(quo[0]), 64'd66);
    check("post_rst_r", 64'(rem[0]), 64'd2);
    step_a(1'b0, 1'b1, zero_a, zero_d);

    // 16-bit extremes on the second instance
    ba = '0;
    ba[0] = 16'hFFFF;
    ba[1] = 16'd1234;
    run_b(ba, 16'd1, 65535, 0);
    ba[1] = 16'hFFFE;
    ba[2] = 16'd1;
    run_b(ba, 16'hFFFF, 1, 0);
    ba[0] = 16'd5;
    ba[1] = 16'd9;
    ba[3] = 16'd8;
    run_b(ba, 16'd9, 0, 5);

    // Randomised traffic with valid/ready gaps
    base = got;
    issued = 0;
    target = 1000;
    pend = 1'b0;
    for (int k = 0; k < 40000 && (got - base) < target; k++) begin
      if (!pend && issued < target) begin
        pend = ($urandom_range(0, 3) != 0);
        if (pend) rand_ops(ra, rd);
      end
      step_a(pend, ($urandom_range(0, 2) != 0), ra, rd);
      if (acc) begin
        pend = 1'b0;
        issued++;
      end
    end
    check("rand_count", 64'(got - base), 64'(target));
    check("rand_drained", 64'(q_exp.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
